pkt_fifo: RTL and testbench

Store-and-forward packet FIFO on Avalon-ST, successor to the single-beat fifo. It buffers write-side beats and presents a packet on the read side only once its eop beat is stored. It is parametrised in data width and depth. It adds packet counting, oversize-packet release, and an optional drop-on-full mode. It sits between Avalon-ST producers and consumers that require whole packets, e.g. checksum or egress framers.

---
 rtl/pkt_fifo_pkg.sv | 26 ++
 rtl/avalon_st_if.sv | 17 +
 rtl/pkt_fifo_mem.sv | 23 ++
 rtl/pkt_fifo.sv | 193 +++++++++++++++++++
 tb/tb_pkt_fifo.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_fifo_pkg.sv
// Shared types for the store-and-forward packet FIFO.
// The entry type describes one stored beat at the default lane count.
package pkt_fifo_pkg;

  localparam int DATA_BYTES = 1;
  localparam int DROP_CNT_W = 16;

  // A single-byte beat still carries a 1-bit empty field.
  function automatic int empty_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int DATA_W  = 8 * DATA_BYTES;
  localparam int EMPTY_W = empty_w(DATA_BYTES);

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } fifo_entry_t;

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} wr_state_t;
  typedef enum logic       {NORMAL, RELEASE}    rd_state_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle: sink receives beats, source emits them.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 1
);
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [DW-1:0] data;
  logic          vld;
  logic          sop;
  logic          eop;
  logic [EW-1:0] empty;
  logic          rdy;

  modport sink   (input data, vld, sop, eop, empty, output rdy);
  modport source (output data, vld, sop, eop, empty, input rdy);
endinterface

// File: rtl/pkt_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module pkt_fifo_mem #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward Avalon-ST packet FIFO with packet counting.
// Define PKT_FIFO_DROP_EN to drop packets that overflow instead of releasing them cut-through.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 1,
  parameter int FIFO_DEPTH          = 4,
  parameter int PKT_CNT_W           = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  avalon_st_if.sink                        write,
  avalon_st_if.source                      read,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fill_level,
  output logic [PKT_CNT_W-1:0]             pkt_count,
  output logic                             full,
  output logic                             empty,
  output logic [DROP_CNT_W-1:0]            drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW = empty_w(DATA_WIDTH_IN_BYTES);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } entry_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        fill_q, fill_d;
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
  wr_state_t            wr_state_q, wr_state_d;
  entry_t               wr_entry, rd_entry;
  logic                 wr_rdy, rd_vld, hs, push, pop, commit, pkt_dec;

`ifdef PKT_FIFO_DROP_EN
  logic [AW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [CW-1:0]         committed_q, committed_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  abort, drop_done;
`else
  rd_state_t rd_state_q, rd_state_d;
  logic      rel_wr_q, rel_wr_d;
  logic      enter_rel;
`endif

  assign full     = (fill_q == CW'(FIFO_DEPTH));
  assign empty    = (fill_q == '0);
  assign wr_entry = '{data: write.data, sop: write.sop, eop: write.eop, empty: write.empty};

  pkt_fifo_mem #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(entry_t))) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    pkt_d      = pkt_q;
    wr_state_d = wr_state_q;
`ifdef PKT_FIFO_DROP_EN
    // Mid-packet writers are never stalled; an overflowing packet is discarded instead.
    wr_rdy       = !(full && wr_state_q == IDLE);
    rd_vld       = (pkt_q != '0);
    hs           = write.vld && wr_rdy;
    abort        = hs && wr_state_q == IN_PKT && full;
    push         = hs && !abort && wr_state_q != DROP;
    pop          = rd_vld && read.rdy;
    commit       = push && write.eop;
    pkt_dec      = pop && rd_entry.eop;
    drop_done    = (abort && write.eop) || (hs && wr_state_q == DROP && write.eop);
    commit_ptr_d = commit_ptr_q;
    committed_d  = committed_q;
    drop_cnt_d   = drop_cnt_q;
`else
    wr_rdy    = !full;
    rd_vld    = (rd_state_q == RELEASE) ? !empty : (pkt_q != '0);
    hs        = write.vld && wr_rdy;
    push      = hs;
    pop       = rd_vld && read.rdy;
    // The oversize packet's eop is never committed since it was already streaming out.
    commit    = push && write.eop && !rel_wr_q;
    pkt_dec   = pop && rd_entry.eop && rd_state_q == NORMAL;
    enter_rel = rd_state_q == NORMAL && full && pkt_q == '0;
    rd_state_d = rd_state_q;
    rel_wr_d   = rel_wr_q;
    if (enter_rel) begin
      rd_state_d = RELEASE;
      rel_wr_d   = 1'b1;
    end else if (rd_state_q == RELEASE && pop && rd_entry.eop) begin
      rd_state_d = NORMAL;
    end
    if (push && write.eop) rel_wr_d = 1'b0;
`endif

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    if (push && !pop)      fill_d = fill_q + CW'(1);
    else if (!push && pop) fill_d = fill_q - CW'(1);

    if (commit && !pkt_dec)      pkt_d = pkt_q + PKT_CNT_W'(1);
    else if (!commit && pkt_dec) pkt_d = pkt_q - PKT_CNT_W'(1);

    case (wr_state_q)
      IDLE:    if (push && !write.eop) wr_state_d = IN_PKT;
      IN_PKT: begin
`ifdef PKT_FIFO_DROP_EN
        if (abort)                  wr_state_d = write.eop ? IDLE : DROP;
        else if (push && write.eop) wr_state_d = IDLE;
`else
        if (push && write.eop) wr_state_d = IDLE;
`endif
      end
      DROP:    if (hs && write.eop) wr_state_d = IDLE;
      default: wr_state_d = IDLE;
    endcase

`ifdef PKT_FIFO_DROP_EN
    if (pop) committed_d = committed_q - CW'(1);
    if (commit) begin
      commit_ptr_d = wr_ptr_d;
      committed_d  = fill_d;
    end
    // Rewind the partial packet; committed packets ahead of it stay intact.
    if (abort) begin
      wr_ptr_d = commit_ptr_q;
      fill_d   = committed_q - (pop ? CW'(1) : CW'(0));
    end
    if (drop_done && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      pkt_q        <= '0;
      wr_state_q   <= IDLE;
`ifdef PKT_FIFO_DROP_EN
      commit_ptr_q <= '0;
      committed_q  <= '0;
      drop_cnt_q   <= '0;
`else
      rd_state_q   <= NORMAL;
      rel_wr_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      pkt_q        <= pkt_d;
      wr_state_q   <= wr_state_d;
`ifdef PKT_FIFO_DROP_EN
      commit_ptr_q <= commit_ptr_d;
      committed_q  <= committed_d;
      drop_cnt_q   <= drop_cnt_d;
`else
      rd_state_q   <= rd_state_d;
      rel_wr_q     <= rel_wr_d;
`endif
    end
  end

  assign write.rdy   = wr_rdy;
  assign read.vld    = rd_vld;
  assign read.data   = rd_entry.data;
  assign read.sop    = rd_vld && rd_entry.sop;
  assign read.eop    = rd_vld && rd_entry.eop;
  assign read.empty  = rd_entry.empty;
  assign fill_level  = fill_q;
  assign pkt_count   = pkt_q;
`ifdef PKT_FIFO_DROP_EN
  assign drop_cnt    = drop_cnt_q;
`else
  assign drop_cnt    = '0;
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo at DATA_WIDTH_IN_BYTES=1, FIFO_DEPTH=4.
module tb_pkt_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  fill_level;
  logic [2:0]  pkt_count;
  logic        full, empty;
  logic [15:0] drop_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) wr_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(1)) rd_if ();

  pkt_fifo #(.DATA_WIDTH_IN_BYTES(1), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write      (wr_if),
    .read       (rd_if),
    .fill_level (fill_level),
    .pkt_count  (pkt_count),
    .full       (full),
    .empty      (empty),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wbeat(input logic [7:0] d, input logic s, input logic e);
    wr_if.vld   = 1'b1;
    wr_if.data  = d;
    wr_if.sop   = s;
    wr_if.eop   = e;
    wr_if.empty = 1'b0;
  endtask

  task automatic widle();
    wr_if.vld = 1'b0;
    wr_if.sop = 1'b0;
    wr_if.eop = 1'b0;
  endtask

  task automatic head(input string tag, input logic [7:0] d, input logic s, input logic e);
    chk({tag, ".vld"},  32'(rd_if.vld),  32'd1);
    chk({tag, ".data"}, 32'(rd_if.data), 32'(d));
    chk({tag, ".sop"},  32'(rd_if.sop),  32'(s));
    chk({tag, ".eop"},  32'(rd_if.eop),  32'(e));
  endtask

  initial begin
    widle();
    wr_if.data  = '0;
    wr_if.empty = '0;
    rd_if.rdy   = 1'b1;
    tick();
    tick();
    chk("rst.fill",  32'(fill_level), 0);
    chk("rst.pkt",   32'(pkt_count),  0);
    chk("rst.full",  32'(full),       0);
    chk("rst.empty", 32'(empty),      1);
    chk("rst.rvld",  32'(rd_if.vld),  0);
    chk("rst.rsop",  32'(rd_if.sop),  0);
    chk("rst.reop",  32'(rd_if.eop),  0);
    chk("rst.wrdy",  32'(wr_if.rdy),  1);
    chk("rst.drop",  32'(drop_cnt),   0);
    rst_n = 1'b1;

    // 1: three-beat packet is held back until its eop is stored
    wbeat(8'h01, 1, 0); tick();
    chk("t1.fill1", 32'(fill_level), 1);
    chk("t1.vld1",  32'(rd_if.vld),  0);
    wbeat(8'h02, 0, 0); tick();
    chk("t1.vld2",  32'(rd_if.vld),  0);
    wbeat(8'h03, 0, 1);
    chk("t1.vld3",  32'(rd_if.vld),  0);
    tick(); widle();
    chk("t1.pkt1",  32'(pkt_count),  1);
    head("t1.b1", 8'h01, 1, 0);
    tick(); head("t1.b2", 8'h02, 0, 0);
    tick(); head("t1.b3", 8'h03, 0, 1);
    tick();
    chk("t1.pkt0",  32'(pkt_count),  0);
    chk("t1.vld0",  32'(rd_if.vld),  0);
    chk("t1.empty", 32'(empty),      1);

    // 2: four single-beat packets fill the buffer
    rd_if.rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wbeat(8'h10 + 8'(i), 1, 1);
      tick();
    end
    widle();
    chk("t2.full", 32'(full),       1);
    chk("t2.fill", 32'(fill_level), 4);
    chk("t2.pkt",  32'(pkt_count),  4);
    chk("t2.wrdy", 32'(wr_if.rdy),  0);
    head("t2.h0", 8'h10, 1, 1);
    rd_if.rdy = 1'b1;
    chk("t2.wrdy_hold", 32'(wr_if.rdy), 0);
    tick();
    chk("t2.wrdy_up", 32'(wr_if.rdy),  1);
    chk("t2.fill3",   32'(fill_level), 3);
    chk("t2.pkt3",    32'(pkt_count),  3);
    head("t2.h1", 8'h11, 1, 1);
    tick(); head("t2.h2", 8'h12, 1, 1);
    tick(); head("t2.h3", 8'h13, 1, 1);
    tick();
    chk("t2.empty", 32'(empty),     1);
    chk("t2.pkt0",  32'(pkt_count), 0);
    chk("t2.vld0",  32'(rd_if.vld), 0);

`ifndef PKT_FIFO_DROP_EN
    // 3: six-beat packet overflows and is released cut-through
    rd_if.rdy = 1'b0;
    wbeat(8'h21, 1, 0); tick();
    wbeat(8'h22, 0, 0); tick();
    wbeat(8'h23, 0, 0); tick();
    wbeat(8'h24, 0, 0); tick();
    wbeat(8'h25, 0, 0);
    chk("t3.full",  32'(full),      1);
    chk("t3.vldn",  32'(rd_if.vld), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t3.pkt",   32'(pkt_count), 0);
    chk("t3.wrdy",  32'(wr_if.rdy), 0);
    head("t3.h21", 8'h21, 1, 0);
    rd_if.rdy = 1'b1;
    tick(); head("t3.h22", 8'h22, 0, 0);
    chk("t3.fill_a", 32'(fill_level), 3);
    tick(); head("t3.h23", 8'h23, 0, 0);
    chk("t3.fill_b", 32'(fill_level), 3);
    wbeat(8'h26, 0, 1);
    tick(); widle();
    head("t3.h24", 8'h24, 0, 0);
    chk("t3.pkt_eop", 32'(pkt_count), 0);
    tick(); head("t3.h25", 8'h25, 0, 0);
    tick(); head("t3.h26", 8'h26, 0, 1);
    tick();
    chk("t3.vld0",  32'(rd_if.vld),  0);
    chk("t3.fill0", 32'(fill_level), 0);
    chk("t3.pkt0",  32'(pkt_count),  0);
    // back in NORMAL: a popped eop must decrement pkt_count again
    wbeat(8'h27, 1, 1); tick(); widle();
    head("t3.h27", 8'h27, 1, 1);
    tick();
    chk("t3.norm_pkt", 32'(pkt_count), 0);
    chk("t3.norm_vld", 32'(rd_if.vld), 0);
`endif

    // 4: write-eop of B coincides with read-eop of A
    rd_if.rdy = 1'b0;
    wbeat(8'h31, 1, 0); tick();
    wbeat(8'h32, 0, 1); tick();
    chk("t4.pkt1", 32'(pkt_count),  1);
    chk("t4.fill", 32'(fill_level), 2);
    wbeat(8'h41, 1, 0);
    rd_if.rdy = 1'b1;
    tick();
    head("t4.a2", 8'h32, 0, 1);
    chk("t4.fill_a", 32'(fill_level), 2);
    wbeat(8'h42, 0, 1);
    tick(); widle();
    chk("t4.pkt_hold", 32'(pkt_count),  1);
    chk("t4.fill_b",   32'(fill_level), 2);
    head("t4.b1", 8'h41, 1, 0);
    tick(); head("t4.b2", 8'h42, 0, 1);
    tick();
    chk("t4.pkt0",  32'(pkt_count), 0);
    chk("t4.empty", 32'(empty),     1);

    // 5: reset mid-packet with a committed packet present
    rd_if.rdy = 1'b0;
    wbeat(8'h51, 1, 1); tick();
    wbeat(8'h61, 1, 0); tick(); widle();
    chk("t5.fill2", 32'(fill_level), 2);
    chk("t5.pkt1",  32'(pkt_count),  1);
    rst_n = 1'b0;
    rd_if.rdy = 1'b1;
    tick();
    chk("t5.fill",  32'(fill_level), 0);
    chk("t5.empty", 32'(empty),      1);
    chk("t5.vld",   32'(rd_if.vld),  0);
    chk("t5.wrdy",  32'(wr_if.rdy),  1);
    chk("t5.pkt",   32'(pkt_count),  0);
    rst_n = 1'b1;
    tick(); tick();
    chk("t5.post_vld", 32'(rd_if.vld), 0);

`ifdef PKT_FIFO_DROP_EN
    // 6: oversize packet is discarded, committed one survives
    rd_if.rdy = 1'b0;
    wbeat(8'h71, 1, 0); tick();
    wbeat(8'h72, 0, 1); tick();
    wbeat(8'h81, 1, 0); tick();
    wbeat(8'h82, 0, 0); tick();
    chk("t6.full", 32'(full),      1);
    chk("t6.wrdy", 32'(wr_if.rdy), 1);
    wbeat(8'h83, 0, 0); tick();
    chk("t6.rewind", 32'(fill_level), 2);
    wbeat(8'h84, 0, 0); tick();
    wbeat(8'h85, 0, 1); tick(); widle();
    chk("t6.drop", 32'(drop_cnt),   1);
    chk("t6.fill", 32'(fill_level), 2);
    chk("t6.pkt",  32'(pkt_count),  1);
    rd_if.rdy = 1'b1;
    head("t6.h71", 8'h71, 1, 0);
    tick(); head("t6.h72", 8'h72, 0, 1);
    tick();
    chk("t6.vld0",  32'(rd_if.vld), 0);
    chk("t6.empty", 32'(empty),     1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
